// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - clocked instruction memory with program-load phase, one-cycle fetch, stall hold and fault reporting
module instr_mem_fetch #(
   parameter int          DEPTH     = 128,
   parameter int          AW        = 32,
   parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [31:0]   prog_data,
   input  logic          prog_done,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   input  logic          stall,
   output logic [31:0]   instru,
   output logic [5:0]    ctr,
   output logic [5:0]    funcode,
   output logic [AW-1:0] fetch_pc,
   output logic          valid,
   output logic          fault,
   output logic          running
);

   localparam int            IW    = $clog2(DEPTH);
   localparam logic [AW-3:0] LIMIT = (AW-2)'(DEPTH);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   instru_q, instru_d;
   logic [AW-1:0] fetch_pc_q, fetch_pc_d;
   logic          valid_q, valid_d;
   logic          fault_q, fault_d;

   // Words are stored XOR HALT_WORD so that all-zero power-up storage reads back as HALT_WORD.
   logic [31:0]   mem_q [DEPTH];

   logic          prog_legal;
   logic          fetch_legal;
   logic          mem_we;
   logic [IW-1:0] prog_idx;
   logic [IW-1:0] fetch_idx;
   logic [31:0]   rd_word;

   // Indices are compared in full width so high addresses never alias onto low words.
   function automatic logic addr_legal(input logic [AW-1:0] a);
      return (a[1:0] == 2'b00) && (a[AW-1:2] < LIMIT);
   endfunction

   always_comb begin
      prog_legal  = addr_legal(prog_addr);
      fetch_legal = addr_legal(fetch_addr);
      prog_idx    = prog_addr[IW+1:2];
      fetch_idx   = fetch_addr[IW+1:2];
      rd_word     = mem_q[fetch_idx] ^ HALT_WORD;
      mem_we      = rst_n && (state_q == ST_LOAD) && prog_we && prog_legal;
   end

   always_comb begin
      state_d    = state_q;
      instru_d   = instru_q;
      fetch_pc_d = fetch_pc_q;
      valid_d    = valid_q;
      fault_d    = fault_q;

      case (state_q)
         ST_LOAD: begin
            if (prog_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               if (fetch_req) begin
                  fetch_pc_d = fetch_addr;
                  if (fetch_legal) begin
                     instru_d = rd_word;
                     valid_d  = 1'b1;
                     fault_d  = 1'b0;
                  end else begin
                     instru_d = HALT_WORD;
                     valid_d  = 1'b0;
                     fault_d  = 1'b1;
                  end
               end else begin
                  instru_d = HALT_WORD;
                  valid_d  = 1'b0;
                  fault_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         instru_q   <= HALT_WORD;
         fetch_pc_q <= '0;
         valid_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         instru_q   <= instru_d;
         fetch_pc_q <= fetch_pc_d;
         valid_q    <= valid_d;
         fault_q    <= fault_d;
      end
   end

   // Program storage has no reset so a loaded program survives rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[prog_idx] <= prog_data ^ HALT_WORD;
      end
   end

   assign instru   = instru_q;
   assign ctr      = instru_q[31:26];
   assign funcode  = instru_q[5:0];
   assign fetch_pc = fetch_pc_q;
   assign valid    = valid_q;
   assign fault    = fault_q;
   assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb/tb_instr_mem_fetch.sv - scoreboard bench for instr_mem_fetch
module tb_instr_mem_fetch;

   localparam int          AW = 32;
   localparam logic [31:0] HW = 32'hFC000000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;
   logic          prog_done;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          stall;
   logic [31:0]   instru;
   logic [5:0]    ctr;
   logic [5:0]    funcode;
   logic [AW-1:0] fetch_pc;
   logic          valid;
   logic          fault;
   logic          running;

   always #5 clk = ~clk;

   instr_mem_fetch #(
      .DEPTH     (128),
      .AW        (AW),
      .HALT_WORD (HW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_done  (prog_done),
      .fetch_req  (fetch_req),
      .fetch_addr (fetch_addr),
      .stall      (stall),
      .instru     (instru),
      .ctr        (ctr),
      .funcode    (funcode),
      .fetch_pc   (fetch_pc),
      .valid      (valid),
      .fault      (fault),
      .running    (running)
   );

   typedef struct {
      string       name;
      logic [31:0] instru;
      logic [31:0] pc;
      logic        v;
      logic        f;
      logic        run;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({e.name, ".instru"},   instru,            e.instru);
            chk({e.name, ".ctr"},      {26'b0, ctr},      {26'b0, e.instru[31:26]});
            chk({e.name, ".funcode"},  {26'b0, funcode},  {26'b0, e.instru[5:0]});
            chk({e.name, ".fetch_pc"}, fetch_pc,          e.pc);
            chk({e.name, ".valid"},    {31'b0, valid},    {31'b0, e.v});
            chk({e.name, ".fault"},    {31'b0, fault},    {31'b0, e.f});
            chk({e.name, ".running"},  {31'b0, running},  {31'b0, e.run});
         end
      end
   end

   task automatic step(input string n, input logic rst, input logic we, input logic [31:0] pa,
                       input logic [31:0] pd, input logic done, input logic req,
                       input logic [31:0] fa, input logic stl, input logic c,
                       input logic [31:0] e_i, input logic [31:0] e_pc,
                       input logic e_v, input logic e_f, input logic e_r);
      exp_t e;
      @(negedge clk);
      rst_n      = rst;
      prog_we    = we;
      prog_addr  = pa;
      prog_data  = pd;
      prog_done  = done;
      fetch_req  = req;
      fetch_addr = fa;
      stall      = stl;
      if (c) begin
         e.name = n; e.instru = e_i; e.pc = e_pc; e.v = e_v; e.f = e_f; e.run = e_r;
         sb_q.push_back(e);
      end
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_done = 1'b0;
      fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;

      //      name          rst we  paddr         pdata         done req faddr         stl chk exp_instru    exp_pc        v  f  run
      step("reset0",        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, HW,           32'h0,        0, 0, 0);
      step("reset1",        0, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, HW,           32'h0,        0, 0, 0);
      step("load_w0",       1, 1, 32'h0,        32'h20080005, 0, 1, 32'h0,        0, 1, HW,           32'h0,        0, 0, 0);
      step("load_w4",       1, 1, 32'h4,        32'h01095020, 0, 1, 32'h4,        0, 1, HW,           32'h0,        0, 0, 0);
      step("load_oor",      1, 1, 32'h200,      32'hDEADBEEF, 0, 0, 32'h0,        0, 1, HW,           32'h0,        0, 0, 0);
      step("load_mis",      1, 1, 32'h1,        32'h11111111, 0, 0, 32'h0,        0, 1, HW,           32'h0,        0, 0, 0);
      step("done",          1, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 1, HW,           32'h0,        0, 0, 1);
      step("fetch0",        1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 1, 32'h20080005, 32'h0,        1, 0, 1);
      step("fetch4",        1, 0, 32'h0,        32'h0,        0, 1, 32'h4,        0, 1, 32'h01095020, 32'h4,        1, 0, 1);
      step("fault_mis",     1, 0, 32'h0,        32'h0,        0, 1, 32'h2,        0, 1, HW,           32'h2,        0, 1, 1);
      step("fault_oor",     1, 0, 32'h0,        32'h0,        0, 1, 32'h200,      0, 1, HW,           32'h200,      0, 1, 1);
      step("bubble",        1, 0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 1, HW,           32'h200,      0, 0, 1);
      step("pre_stall",     1, 0, 32'h0,        32'h0,        0, 1, 32'h4,        0, 1, 32'h01095020, 32'h4,        1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step("stall_hold", 1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        1, 1, 32'h01095020, 32'h4,        1, 0, 1);
      end
      step("stall_rel",     1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 1, 32'h20080005, 32'h0,        1, 0, 1);
      step("rst_mid_run",   0, 0, 32'h0,        32'h0,        0, 1, 32'h4,        0, 1, HW,           32'h0,        0, 0, 0);
      step("we_with_done",  1, 1, 32'h8,        32'hAAAA0000, 1, 1, 32'h4,        0, 1, HW,           32'h0,        0, 0, 1);
      step("run_we_fetch8", 1, 1, 32'h8,        32'h0,        0, 1, 32'h8,        0, 1, 32'hAAAA0000, 32'h8,        1, 0, 1);
      step("refetch8",      1, 0, 32'h0,        32'h0,        0, 1, 32'h8,        0, 1, 32'hAAAA0000, 32'h8,        1, 0, 1);
      step("retained0",     1, 0, 32'h0,        32'h0,        0, 1, 32'h0,        0, 1, 32'h20080005, 32'h0,        1, 0, 1);
      step("retained4",     1, 0, 32'h0,        32'h0,        0, 1, 32'h4,        0, 1, 32'h01095020, 32'h4,        1, 0, 1);
      step("depth_wrap",    1, 0, 32'h0,        32'h0,        0, 1, 32'h204,      0, 1, HW,           32'h204,      0, 1, 1);

      @(negedge clk);
      @(negedge clk);
      chk("sb_drain", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised, synchronous-read instruction memory for the IF stage of the pipelined processor. Replaces the combinational instruction ROM with a clocked block that has a program-load phase, a one-cycle fetch with stall hold, and fault reporting for misaligned or out-of-range PCs. It decodes the opcode and funct fields alongside the word, and returns the fetched PC so the IF/ID register can latch instruction and PC together.

## Interface
Parameters:
- DEPTH, 128: number of 32-bit words; must be a power of two.
- AW, 32: width of byte addresses (`fetch_addr`, `prog_addr`, `fetch_pc`).
- HALT_WORD, 32'hFC000000: word driven whenever no valid instruction exists (opcode 6'b111111).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- prog_we  in  1  write strobe for program load; honoured only in LOAD.
- prog_addr  in  AW  byte address of the word to write.
- prog_data  in  32  instruction word to write.
- prog_done  in  1  one-cycle pulse; ends LOAD.
- fetch_req  in  1  fetch request from the PC stage.
- fetch_addr  in  AW  byte address (PC) to fetch.
- stall  in  1  hazard stall; holds all fetch outputs.
- instru  out  32  fetched instruction word.
- ctr  out  6  `instru[31:26]`.
- funcode  out  6  `instru[5:0]`.
- fetch_pc  out  AW  address that produced the current `instru`.
- valid  out  1  `instru` is a real fetched instruction.
- fault  out  1  last fetch was misaligned or out of range.
- running  out  1  high in state RUN.

## Operation
- Storage is DEPTH x 32. Every word is HALT_WORD at time zero. Contents are not cleared by `rst_n`, so a program survives reset.
- Word index = `addr[AW-1:2]`.
  - An address is out of range when the index is DEPTH or greater.
  - An address is misaligned when `addr[1:0]` is not 0.
- FSM states: LOAD and RUN.
  - Reset enters LOAD.
  - LOAD goes to RUN on the edge where `prog_done` is 1.
  - RUN has no exit except reset.
- LOAD behaviour:
  - `prog_we` with a legal address writes `prog_data`.
  - Illegal addresses are dropped silently.
  - `fetch_req` is ignored.
  - Outputs hold their reset values.
- If `prog_we` and `prog_done` occur in the same cycle, the write completes and the state moves to RUN. The written word is readable on the next cycle.
- In RUN, `prog_we` is ignored; the memory is read-only.
- Fetch in RUN, with `stall` = 0 and `fetch_req` = 1:
  - Legal address: `instru` is loaded with `mem[index]`, `fetch_pc` with `fetch_addr`, `valid` = 1, `fault` = 0.
  - Illegal address: `instru` = HALT_WORD, `fetch_pc` = `fetch_addr`, `valid` = 0, `fault` = 1.
- RUN with `stall` = 0 and `fetch_req` = 0 (bubble): `instru` = HALT_WORD, `valid` = 0, `fault` = 0, `fetch_pc` holds.
- `stall` = 1: every output holds its value. `stall` wins over `fetch_req`.
- `ctr` and `funcode` are combinational slices of the registered `instru`. They are never derived from the memory array directly.

## Timing
- Reset values, applied on the first edge with `rst_n` = 0:
  - `instru` = HALT_WORD, so `ctr` = 6'h3F and `funcode` = 6'h00.
  - `fetch_pc` = 0, `valid` = 0, `fault` = 0, `running` = 0.
- Fetch latency is 1 cycle: a request sampled at edge N appears on the outputs after edge N. A new request is accepted every unstalled cycle.
- `running` rises on the edge that samples `prog_done`. A fetch is accepted from the following edge onward.
- Reset asserted mid-RUN: on that edge the state returns to LOAD and all outputs take their reset values. Memory is untouched. An in-flight fetch is discarded.
- A stall released at edge N: the request present at edge N is accepted at edge N.
- Address wrap: indices are never taken modulo DEPTH. `fetch_addr` = 4*DEPTH faults; it does not alias to word 0.

## Test plan
- Reset → outputs at reset values:
  - Hold `rst_n` low for 2 cycles.
  - Required: `instru` = 32'hFC000000, `ctr` = 6'h3F, `valid` = 0, `fault` = 0, `running` = 0.
- Load then fetch:
  - Write 32'h20080005 to address 0 and 32'h01095020 to address 4, then pulse `prog_done`.
  - Fetch 0 then 4 on back-to-back cycles.
  - Required, one cycle after each request: `instru` = 32'h20080005 (`ctr` = 6'h08), then 32'h01095020 (`funcode` = 6'h20), with `valid` = 1 and `fetch_pc` = 0 then 4.
- Faults:
  - In RUN, fetch 32'h00000002, then 32'h00000200 (DEPTH = 128).
  - Required: `fault` = 1, `valid` = 0, `instru` = HALT_WORD, `fetch_pc` = the requested address.
- Stall hold:
  - Fetch 4, then assert `stall` for 3 cycles while `fetch_req` = 1 with `fetch_addr` = 0.
  - Required: `instru` = 32'h01095020 and `fetch_pc` = 4 throughout the stall, then `instru` = 32'h20080005 one cycle after `stall` falls.
- Write lockout and same-cycle done:
  - Assert `prog_we` (address 8, data 32'hAAAA0000) together with `prog_done`, then in RUN write address 8 with 32'h0.
  - Required: fetch of 8 returns 32'hAAAA0000.
- Reset mid-RUN:
  - Assert `rst_n` low during a fetch, then pulse `prog_done` without reloading and fetch 0.
  - Required: outputs at reset values during reset, then `instru` = 32'h20080005 (contents retained).
